// File: rtl/hilo_mult_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hilo_mult_sequencer_pkg
// Shared definitions for the HI/LO multiply sequencer and the ALU decoder:
//   - ALUControl codes that the sequencer acts on (MULT, MTHI, MTLO, MFHI, MFLO)
//   - default operand width and iteration count
//   - FSM state encoding of the sequencer
//   - helper that classifies HI/LO access instructions
// ---------------------------------------------------------------------------
package hilo_mult_sequencer_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    // One radix-2 step per operand bit.
    localparam int DEFAULT_MULT_CYCLES = 32;

    localparam logic [4:0] ALU_MULT = 5'b10001;
    localparam logic [4:0] ALU_MTHI = 5'b01111;
    localparam logic [4:0] ALU_MTLO = 5'b10000;
    localparam logic [4:0] ALU_MFHI = 5'b01101;
    localparam logic [4:0] ALU_MFLO = 5'b01110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } mult_state_t;

    // True for instructions that read or write HI/LO and therefore must wait
    // while a multiply is still producing its result.
    function automatic logic is_hilo_access(input logic [4:0] code);
        return (code == ALU_MFHI) || (code == ALU_MFLO) ||
               (code == ALU_MTHI) || (code == ALU_MTLO);
    endfunction

endpackage

// File: rtl/hilo_mult_sequencer_if.sv
// ---------------------------------------------------------------------------
// hilo_mult_sequencer_if
// Bundles the decoder/datapath-facing signals of the multiply sequencer.
//   alu_control  decoder -> sequencer  ALUControl code
//   unsigned_op  decoder -> sequencer  1 = multu, 0 = mult
//   rs_data      decoder -> sequencer  multiplicand / mthi-mtlo write data
//   rt_data      decoder -> sequencer  multiplier
//   hi, lo       sequencer -> pipeline registered HI/LO
//   busy         sequencer -> pipeline multiply in progress
//   done         sequencer -> pipeline one-cycle pulse after HI/LO update
//   stall        sequencer -> pipeline hold PC and register-file write
// master = pipeline/decoder side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface hilo_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       alu_control;
    logic             unsigned_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output alu_control, unsigned_op, rs_data, rt_data,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  alu_control, unsigned_op, rs_data, rt_data,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/hilo_mult_sequencer_mult_iter_datapath.sv
// ---------------------------------------------------------------------------
// mult_iter_datapath
// Iterative radix-2 shift-add multiplier core: operand magnitude latches,
// 2*WIDTH accumulator and step counter. Sign handling of the final product is
// left to the controller, which uses the latched neg flag.
//   clk, rst_n    clock, asynchronous active-low reset
//   load          latch operands and clear accumulator/counter
//   step          perform one shift-add step
//   unsigned_op   operands are unsigned when 1
//   rs_data       multiplicand
//   rt_data       multiplier
//   acc           unsigned magnitude product accumulator
//   neg           product must be negated
//   last_step     current step is the final one
// ---------------------------------------------------------------------------
module mult_iter_datapath #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 unsigned_op,
    input  logic [WIDTH-1:0]     rs_data,
    input  logic [WIDTH-1:0]     rt_data,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 neg,
    output logic                 last_step
);
    localparam int CNT_W = $clog2(MULT_CYCLES) + 1;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               neg_reg;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] addend;

    // Magnitude of the most negative value wraps back to 2^(WIDTH-1), which
    // is exactly right when read as an unsigned number.
    assign rs_neg = ~unsigned_op & rs_data[WIDTH-1];
    assign rt_neg = ~unsigned_op & rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign rt_mag = rt_neg ? (~rt_data + 1'b1) : rt_data;

    // Partial product for this step: shifted multiplicand gated by the
    // current multiplier LSB.
    genvar gi;
    generate
        for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
        end else if (load) begin
            mcand_reg  <= {{WIDTH{1'b0}}, rs_mag};
            mplier_reg <= rt_mag;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= rs_neg ^ rt_neg;
        end else if (step) begin
            acc_reg    <= acc_reg + addend;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
        end
    end

    assign acc       = acc_reg;
    assign neg       = neg_reg;
    assign last_step = step && (count_reg == CNT_W'(MULT_CYCLES - 1));

endmodule

// File: rtl/hilo_mult_sequencer.sv
// ---------------------------------------------------------------------------
// hilo_mult_sequencer
// HI/LO register pair with an iterative multiplier for mult/multu, plus
// mthi/mtlo writes and the pipeline stall request.
//   clk    clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of hilo_mult_sequencer_if (alu_control, unsigned_op,
//          rs_data, rt_data in; hi, lo, busy, done, stall out)
// A product becomes visible in HI/LO MULT_CYCLES+1 edges after the start edge;
// done follows for one cycle, during which stall is released so the held
// mult instruction retires without starting again.
// ---------------------------------------------------------------------------
module hilo_mult_sequencer
    import hilo_mult_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hilo_mult_sequencer_if.slave   bus
);
    mult_state_t        state_reg;
    mult_state_t        state_next;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               start;
    logic               busy;
    logic               hilo_blocked;
    logic               last_step;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;

    // ~done_reg keeps the still-present mult from relaunching in the cycle it
    // retires.
    assign start        = (bus.alu_control == ALU_MULT) && (state_reg == ST_IDLE) && !done_reg;
    assign busy         = (state_reg == ST_CALC) || (state_reg == ST_SIGN);
    assign hilo_blocked = busy && is_hilo_access(bus.alu_control);

    mult_iter_datapath #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (start),
        .step        (state_reg == ST_CALC),
        .unsigned_op (bus.unsigned_op),
        .rs_data     (bus.rs_data),
        .rt_data     (bus.rt_data),
        .acc         (acc),
        .neg         (neg),
        .last_step   (last_step)
    );

    assign product = neg ? (~acc + 1'b1) : acc;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)     state_next = ST_CALC;
            ST_CALC: if (last_step) state_next = ST_SIGN;
            ST_SIGN:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_SIGN);
        end
    end

    // HI/LO only change on the single SIGN cycle or on an idle move, so a
    // partial product is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == ST_SIGN) begin
            {hi_reg, lo_reg} <= product;
        end else if (state_reg == ST_IDLE) begin
            if (bus.alu_control == ALU_MTHI) hi_reg <= bus.rs_data;
            if (bus.alu_control == ALU_MTLO) lo_reg <= bus.rs_data;
        end
    end

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;
    assign bus.busy  = busy;
    assign bus.done  = done_reg;
    assign bus.stall = start | busy | hilo_blocked;

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hilo_mult_sequencer
// Self-checking bench: directed and random mult/multu operations compared
// against a plain-arithmetic reference product, plus HI/LO moves, busy
// blocking, back-to-back issue and reset abort.
// ---------------------------------------------------------------------------
module tb_hilo_mult_sequencer;
    import hilo_mult_sequencer_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = 34;   // stall-high samples for one multiply

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    hilo_mult_sequencer_if #(.WIDTH(W)) bus_if ();

    hilo_mult_sequencer #(.WIDTH(W), .MULT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product from ordinary integer arithmetic.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input bit uns);
        longint sa;
        longint sb;
        if (uns) return {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits until stall drops; reports cycles taken and whether HI/LO stayed
    // frozen while stall was high.
    task automatic run_until_done(output int cycles, output bit held);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = bus_if.hi;
        prev_lo = bus_if.lo;
        cycles  = 0;
        held    = 1'b1;
        while (bus_if.stall === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
            if (bus_if.stall === 1'b1 && (bus_if.hi !== prev_hi || bus_if.lo !== prev_lo))
                held = 1'b0;
        end
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit uns,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string name);
        int cycles;
        bit held;
        bus_if.alu_control = ALU_MULT;
        bus_if.rs_data     = a;
        bus_if.rt_data     = b;
        bus_if.unsigned_op = uns;
        #1;
        checks++; if (bus_if.stall !== 1'b1) begin failures++; $display("FAIL %s_start_stall: got %b expected 1", name, bus_if.stall); end
        run_until_done(cycles, held);
        $display("mult %s rs=%h rt=%h uns=%0d -> hi=%h lo=%h cycles=%0d", name, a, b, uns, bus_if.hi, bus_if.lo, cycles);
        checks++; if (cycles != LATENCY) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, cycles, LATENCY); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL %s_partial: hi/lo changed while stalled, got %b expected 1", name, held); end
        checks++; if (bus_if.hi !== exp_hi) begin failures++; $display("FAIL %s_hi: got %h expected %h", name, bus_if.hi, exp_hi); end
        checks++; if (bus_if.lo !== exp_lo) begin failures++; $display("FAIL %s_lo: got %h expected %h", name, bus_if.lo, exp_lo); end
        checks++; if (bus_if.done !== 1'b1) begin failures++; $display("FAIL %s_done: got %b expected 1", name, bus_if.done); end
        // The mult is still presented during the done cycle; it must not restart.
        tick();
        checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin failures++; $display("FAIL %s_no_restart: got busy=%b done=%b expected 0 0", name, bus_if.busy, bus_if.done); end
        bus_if.alu_control = 5'b00000;
        #1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus_if.alu_control = 5'b00000;
        bus_if.unsigned_op = 1'b0;
        bus_if.rs_data     = '0;
        bus_if.rt_data     = '0;
        tick();
        tick();
        checks++; if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) begin failures++; $display("FAIL reset_hilo: got %h_%h expected 0_0", bus_if.hi, bus_if.lo); end
        checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.stall !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b done=%b stall=%b expected 0 0 0", bus_if.busy, bus_if.done, bus_if.stall); end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_directed();
        do_mult(32'd3,          32'd5,          1'b0, 32'h00000000, 32'h0000000F, "s_3x5");
        do_mult(32'hFFFFFFFE,   32'd3,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, "s_m2x3");
        do_mult(32'h80000000,   32'h80000000,   1'b0, 32'h40000000, 32'h00000000, "s_min_sq");
        do_mult(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFE, 32'h00000001, "u_max_sq");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        bit          uns;
        logic [63:0] p;
        for (int i = 0; i < 10; i++) begin
            a   = $urandom;
            b   = $urandom;
            uns = 1'($urandom_range(0, 1));
            if (i == 2) a = 32'h80000000;
            if (i == 3) b = 32'h7FFFFFFF;
            p = ref_product(a, b, uns);
            do_mult(a, b, uns, p[63:32], p[31:0], $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_hilo_moves();
        logic [31:0] v;
        logic [31:0] old_hi;
        v      = $urandom;
        old_hi = bus_if.hi;
        bus_if.alu_control = ALU_MTLO;
        bus_if.rs_data     = v;
        tick();
        $display("mtlo rs=%h -> hi=%h lo=%h", v, bus_if.hi, bus_if.lo);
        checks++; if (bus_if.lo !== v || bus_if.hi !== old_hi) begin failures++; $display("FAIL mtlo_idle: got %h_%h expected %h_%h", bus_if.hi, bus_if.lo, old_hi, v); end
        v = $urandom;
        bus_if.alu_control = ALU_MTHI;
        bus_if.rs_data     = v;
        tick();
        $display("mthi rs=%h -> hi=%h lo=%h", v, bus_if.hi, bus_if.lo);
        checks++; if (bus_if.hi !== v) begin failures++; $display("FAIL mthi_idle: got %h expected %h", bus_if.hi, v); end
        bus_if.alu_control = ALU_MFHI;
        #1;
        checks++; if (bus_if.stall !== 1'b0) begin failures++; $display("FAIL mfhi_idle_stall: got %b expected 0", bus_if.stall); end
        bus_if.alu_control = 5'b00000;
        tick();
    endtask

    task automatic test_mthi_busy();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          cycles;
        bit          held;
        a = $urandom;
        b = $urandom;
        p = ref_product(a, b, 1'b0);
        bus_if.alu_control = ALU_MULT;
        bus_if.unsigned_op = 1'b0;
        bus_if.rs_data     = a;
        bus_if.rt_data     = b;
        tick();
        for (int i = 0; i < 4; i++) tick();
        bus_if.alu_control = ALU_MFHI;
        #1;
        checks++; if (bus_if.stall !== 1'b1) begin failures++; $display("FAIL mfhi_busy_stall: got %b expected 1", bus_if.stall); end
        tick();
        // New rs on the bus must not leak into the running multiply.
        bus_if.alu_control = ALU_MTHI;
        bus_if.rs_data     = 32'h12345678;
        #1;
        checks++; if (bus_if.stall !== 1'b1) begin failures++; $display("FAIL mthi_busy_stall: got %b expected 1", bus_if.stall); end
        run_until_done(cycles, held);
        $display("mult+mthi rs=%h rt=%h -> hi=%h lo=%h", a, b, bus_if.hi, bus_if.lo);
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL mthi_busy_held: got %b expected 1", held); end
        checks++; if (bus_if.hi !== p[63:32] || bus_if.lo !== p[31:0]) begin failures++; $display("FAIL mthi_busy_product: got %h_%h expected %h", bus_if.hi, bus_if.lo, p); end
        tick();
        $display("mthi after idle -> hi=%h lo=%h", bus_if.hi, bus_if.lo);
        checks++; if (bus_if.hi !== 32'h12345678 || bus_if.lo !== p[31:0]) begin failures++; $display("FAIL mthi_after: got %h_%h expected 12345678_%h", bus_if.hi, bus_if.lo, p[31:0]); end
        bus_if.alu_control = 5'b00000;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d;
        logic [63:0] p1, p2;
        int          cycles;
        bit          held;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        p1 = ref_product(a, b, 1'b1);
        p2 = ref_product(c, d, 1'b1);
        bus_if.alu_control = ALU_MULT;
        bus_if.unsigned_op = 1'b1;
        bus_if.rs_data     = a;
        bus_if.rt_data     = b;
        tick();
        for (int i = 0; i < 6; i++) tick();
        bus_if.rs_data = c;
        bus_if.rt_data = d;
        #1;
        run_until_done(cycles, held);
        $display("b2b first rs=%h rt=%h -> hi=%h lo=%h", a, b, bus_if.hi, bus_if.lo);
        checks++; if (bus_if.hi !== p1[63:32] || bus_if.lo !== p1[31:0]) begin failures++; $display("FAIL b2b_first: got %h_%h expected %h", bus_if.hi, bus_if.lo, p1); end
        tick();
        checks++; if (bus_if.busy !== 1'b0 || bus_if.stall !== 1'b1) begin failures++; $display("FAIL b2b_gap: got busy=%b stall=%b expected 0 1", bus_if.busy, bus_if.stall); end
        run_until_done(cycles, held);
        $display("b2b second rs=%h rt=%h -> hi=%h lo=%h cycles=%0d", c, d, bus_if.hi, bus_if.lo, cycles);
        checks++; if (cycles != LATENCY) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", cycles, LATENCY); end
        checks++; if (bus_if.hi !== p2[63:32] || bus_if.lo !== p2[31:0]) begin failures++; $display("FAIL b2b_second: got %h_%h expected %h", bus_if.hi, bus_if.lo, p2); end
        bus_if.alu_control = 5'b00000;
        tick();
    endtask

    task automatic test_reset_abort();
        bus_if.alu_control = ALU_MULT;
        bus_if.unsigned_op = 1'b0;
        bus_if.rs_data     = 32'h00001234;
        bus_if.rt_data     = 32'h00005678;
        tick();
        for (int i = 0; i < 9; i++) tick();
        checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before: got %b expected 1", bus_if.busy); end
        rst_n = 1'b0;
        #1;
        $display("reset mid-multiply -> hi=%h lo=%h busy=%b", bus_if.hi, bus_if.lo, bus_if.busy);
        checks++; if (bus_if.hi !== 32'h0 || bus_if.lo !== 32'h0) begin failures++; $display("FAIL abort_hilo: got %h_%h expected 0_0", bus_if.hi, bus_if.lo); end
        checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done); end
        bus_if.alu_control = 5'b00000;
        tick();
        rst_n = 1'b1;
        tick();
        do_mult(32'd7, 32'd6, 1'b0, 32'h00000000, 32'h0000002A, "after_reset_7x6");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hilo_moves();
        test_mthi_busy();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
